// File: rtl/iobufds_blvds_bank.sv
// iobufds_blvds_bank: multi-channel bidirectional BLVDS pad bank.
// The transmit data is registered. A committed turnaround FSM keeps every pad
// tristated for TURN_CYCLES cycles on each direction change. Each channel's
// receive pair is sampled and decoded, then passed through a
// consecutive-sample glitch filter. A saturating counter tracks receive
// cycles that saw an invalid pair.
module iobufds_blvds_bank #(
  parameter int WIDTH       = 8,
  parameter int TURN_CYCLES = 2,
  parameter int FILTER      = 2,
  parameter int CNT_W       = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] I,
  input  logic             DRIVE_REQ,
  input  logic             ERR_CLR,
  inout  wire  [WIDTH-1:0] IO,
  inout  wire  [WIDTH-1:0] IOB,
  output logic [WIDTH-1:0] O,
  output logic             DRIVING,
  output logic             BUSY,
  output logic             RX_VALID,
  output logic [CNT_W-1:0] ERR_CNT
);

  localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam int FW = $clog2(FILTER + 1);

  typedef enum logic [1:0] {
    ST_RX      = 2'd0,
    ST_TURN_TX = 2'd1,
    ST_TX      = 2'd2,
    ST_TURN_RX = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [TW-1:0]           turn_q, turn_d;
  logic [WIDTH-1:0]        i_q;
  logic [WIDTH-1:0]        smp_p_q, smp_n_q;
  logic [WIDTH-1:0][FW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]        o_q, o_d;
  logic                    driving_q, busy_q;
  logic                    rx_valid_q, rx_valid_d;
  logic [CNT_W-1:0]        err_q, err_d;
  logic [WIDTH-1:0]        smp_valid_s;
  logic [WIDTH-1:0]        pad_valid_s;
  logic                    drive_en_s;

  // A pair is valid only for the two complementary codes. X/Z never match
  // 1'b1 under case equality, so they count as invalid in simulation.
  function automatic logic pair_valid(input logic p, input logic n);
    return ((p ^ n) === 1'b1);
  endfunction

  // The pad enable comes only from the state register. Reset releases the
  // pads without waiting for a clock edge.
  assign drive_en_s = (state_q == ST_TX);
  assign IO         = drive_en_s ? i_q  : {WIDTH{1'bz}};
  assign IOB        = drive_en_s ? ~i_q : {WIDTH{1'bz}};

  assign O        = o_q;
  assign DRIVING  = driving_q;
  assign BUSY     = busy_q;
  assign RX_VALID = rx_valid_q;
  assign ERR_CNT  = err_q;

  // Next-state logic for the turnaround FSM. Once a turnaround starts it
  // runs to its target state.
  always_comb begin
    state_d = state_q;
    turn_d  = turn_q;
    case (state_q)
      ST_RX: begin
        if (DRIVE_REQ) begin
          if (TURN_CYCLES == 0) begin
            state_d = ST_TX;
          end else begin
            state_d = ST_TURN_TX;
            turn_d  = TW'(TURN_CYCLES - 1);
          end
        end else begin
          state_d = ST_RX;
        end
      end
      ST_TURN_TX: begin
        if (turn_q == '0) begin
          state_d = ST_TX;
        end else begin
          turn_d = turn_q - TW'(1);
        end
      end
      ST_TX: begin
        if (!DRIVE_REQ) begin
          if (TURN_CYCLES == 0) begin
            state_d = ST_RX;
          end else begin
            state_d = ST_TURN_RX;
            turn_d  = TW'(TURN_CYCLES - 1);
          end
        end else begin
          state_d = ST_TX;
        end
      end
      ST_TURN_RX: begin
        if (turn_q == '0) begin
          state_d = ST_RX;
        end else begin
          turn_d = turn_q - TW'(1);
        end
      end
      default: begin
        state_d = ST_RX;
        turn_d  = '0;
      end
    endcase
  end

  // Per-channel decode and glitch filter. A change reaches O only after
  // FILTER consecutive valid samples that differ from it.
  always_comb begin
    cnt_d       = cnt_q;
    o_d         = o_q;
    smp_valid_s = '0;
    pad_valid_s = '0;
    for (int k = 0; k < WIDTH; k++) begin
      smp_valid_s[k] = pair_valid(smp_p_q[k], smp_n_q[k]);
      pad_valid_s[k] = pair_valid(IO[k], IOB[k]);
      if (!smp_valid_s[k]) begin
        cnt_d[k] = '0;
      end else if (smp_p_q[k] == o_q[k]) begin
        cnt_d[k] = '0;
      end else if ((cnt_q[k] + FW'(1)) == FW'(FILTER)) begin
        o_d[k]   = smp_p_q[k];
        cnt_d[k] = '0;
      end else begin
        cnt_d[k] = cnt_q[k] + FW'(1);
      end
    end
  end

  // RX_VALID and the saturating error count. A cycle is charged to the
  // counter when the pair being captured at the edge is invalid while the
  // bank is in RX.
  always_comb begin
    rx_valid_d = (state_q == ST_RX) && (&smp_valid_s) && (cnt_d == '0);
    if (ERR_CLR) begin
      err_d = '0;
    end else if ((state_q == ST_RX) && !(&pad_valid_s) && (err_q != '1)) begin
      err_d = err_q + CNT_W'(1);
    end else begin
      err_d = err_q;
    end
  end

  // State, data, sample, filter and status registers. DRIVING and BUSY are
  // decoded from the next state so they line up with the state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_RX;
      turn_q     <= '0;
      i_q        <= '0;
      smp_p_q    <= '0;
      smp_n_q    <= '0;
      cnt_q      <= '0;
      o_q        <= '0;
      driving_q  <= 1'b0;
      busy_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      turn_q     <= turn_d;
      i_q        <= I;
      smp_p_q    <= IO;
      smp_n_q    <= IOB;
      cnt_q      <= cnt_d;
      o_q        <= o_d;
      driving_q  <= (state_d == ST_TX);
      busy_q     <= (state_d == ST_TURN_TX) || (state_d == ST_TURN_RX);
      rx_valid_q <= rx_valid_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_iobufds_blvds_bank.sv
// Directed bench for iobufds_blvds_bank (WIDTH=8, TURN_CYCLES=2, FILTER=2,
// CNT_W=8). The bench is the far end of the BLVDS bus. Where the DUT should
// be tristated, the bench drives a known value and checks that it reads back
// unchanged.
module tb_iobufds_blvds_bank;

  logic       CLK;
  logic       RST_N;
  logic [7:0] I;
  logic       DRIVE_REQ;
  logic       ERR_CLR;
  wire  [7:0] IO;
  wire  [7:0] IOB;
  logic [7:0] O;
  logic       DRIVING;
  logic       BUSY;
  logic       RX_VALID;
  logic [7:0] ERR_CNT;

  logic       tb_en;
  logic [7:0] tb_io;
  logic [7:0] tb_iob;

  int n_cmp;
  int n_bad;

  assign IO  = tb_en ? tb_io  : 8'hzz;
  assign IOB = tb_en ? tb_iob : 8'hzz;

  iobufds_blvds_bank #(
    .WIDTH(8),
    .TURN_CYCLES(2),
    .FILTER(2),
    .CNT_W(8)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .I(I),
    .DRIVE_REQ(DRIVE_REQ),
    .ERR_CLR(ERR_CLR),
    .IO(IO),
    .IOB(IOB),
    .O(O),
    .DRIVING(DRIVING),
    .BUSY(BUSY),
    .RX_VALID(RX_VALID),
    .ERR_CNT(ERR_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic pads(input logic en, input logic [7:0] p, input logic [7:0] n);
    tb_en  = en;
    tb_io  = p;
    tb_iob = n;
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    RST_N     = 1'b0;
    I         = 8'h00;
    DRIVE_REQ = 1'b0;
    ERR_CLR   = 1'b0;
    pads(1'b1, 8'hA5, 8'h5A);

    // Reset state
    #1;
    chk("rst_O", O, 32'h00);
    chk("rst_DRIVING", DRIVING, 32'h0);
    chk("rst_BUSY", BUSY, 32'h0);
    chk("rst_RX_VALID", RX_VALID, 32'h0);
    chk("rst_ERR", ERR_CNT, 32'h00);
    chk("rst_IO_released", IO, 32'hA5);
    @(posedge CLK);
    @(posedge CLK);
    #3 RST_N = 1'b1;

    // Receive A5: sampled at E1, O updates at E3
    tick(1);
    chk("rx_E1_O", O, 32'h00);
    tick(1);
    chk("rx_E2_O", O, 32'h00);
    chk("rx_E2_RX_VALID", RX_VALID, 32'h0);
    tick(1);
    chk("rx_E3_O", O, 32'hA5);
    chk("rx_E3_RX_VALID", RX_VALID, 32'h1);
    chk("rx_E3_ERR", ERR_CNT, 32'h00);

    // RX -> TX with two tristated turnaround cycles
    DRIVE_REQ = 1'b1;
    I         = 8'h3C;
    tick(1);
    chk("ttx1_BUSY", BUSY, 32'h1);
    chk("ttx1_DRIVING", DRIVING, 32'h0);
    chk("ttx1_IO_z", IO, 32'hA5);
    chk("ttx1_IOB_z", IOB, 32'h5A);
    tick(1);
    chk("ttx2_BUSY", BUSY, 32'h1);
    chk("ttx2_IO_z", IO, 32'hA5);
    chk("ttx2_IOB_z", IOB, 32'h5A);
    pads(1'b0, 8'h00, 8'h00);
    tick(1);
    chk("tx_DRIVING", DRIVING, 32'h1);
    chk("tx_BUSY", BUSY, 32'h0);
    chk("tx_IO_3C", IO, 32'h3C);
    chk("tx_IOB_C3", IOB, 32'hC3);
    I = 8'h96;
    tick(1);
    chk("tx_IO_96", IO, 32'h96);
    chk("tx_IOB_69", IOB, 32'h69);
    chk("tx_RX_VALID", RX_VALID, 32'h0);
    tick(4);
    chk("tx_loopback_O", O, 32'h96);
    chk("tx_ERR", ERR_CNT, 32'h00);

    // TX -> RX, DRIVE_REQ re-raised during TURN_RX is ignored
    DRIVE_REQ = 1'b0;
    tick(1);
    chk("trx1_BUSY", BUSY, 32'h1);
    chk("trx1_DRIVING", DRIVING, 32'h0);
    DRIVE_REQ = 1'b1;
    pads(1'b1, 8'h00, 8'h00);
    tick(1);
    chk("trx2_BUSY", BUSY, 32'h1);
    chk("trx2_IO_z", IO, 32'h00);
    chk("trx2_IOB_z", IOB, 32'h00);
    tick(1);
    chk("rx_back_BUSY", BUSY, 32'h0);
    chk("rx_back_DRIVING", DRIVING, 32'h0);
    chk("rx_back_IO_z", IO, 32'h00);
    chk("turn_no_err", ERR_CNT, 32'h00);
    tick(1);
    chk("ttx_again_BUSY", BUSY, 32'h1);
    chk("ttx_again_IO_z", IO, 32'h00);
    chk("rx_invalid_err", ERR_CNT, 32'h01);
    tick(1);
    pads(1'b0, 8'h00, 8'h00);
    tick(1);
    chk("tx_again_DRIVING", DRIVING, 32'h1);
    DRIVE_REQ = 1'b0;
    tick(1);
    pads(1'b1, 8'hA5, 8'h5A);
    tick(5);
    chk("rx2_O", O, 32'hA5);
    chk("rx2_RX_VALID", RX_VALID, 32'h1);
    chk("rx2_ERR", ERR_CNT, 32'h01);

    // One-cycle glitch on channel 0 is filtered out
    pads(1'b1, 8'hA4, 8'h5B);
    tick(1);
    pads(1'b1, 8'hA5, 8'h5A);
    tick(1);
    chk("glitch1_O", O, 32'hA5);
    chk("glitch1_RX_VALID", RX_VALID, 32'h0);
    tick(1);
    chk("glitch1_O_after", O, 32'hA5);
    chk("glitch1_RX_VALID_after", RX_VALID, 32'h1);

    // Two-cycle change on channel 0 flips O[0]
    pads(1'b1, 8'hA4, 8'h5B);
    tick(2);
    chk("flip_before_O", O, 32'hA5);
    pads(1'b1, 8'hA5, 8'h5A);
    tick(1);
    chk("flip_O", O, 32'hA4);
    tick(2);
    chk("flip_back_O", O, 32'hA5);

    // Invalid (1,1) mid-count restarts the count
    pads(1'b1, 8'hA4, 8'h5B);
    tick(1);
    pads(1'b1, 8'hA5, 8'h5B);
    tick(1);
    chk("mid_inv_ERR", ERR_CNT, 32'h02);
    chk("mid_inv_O1", O, 32'hA5);
    pads(1'b1, 8'hA4, 8'h5B);
    tick(1);
    chk("mid_inv_O2", O, 32'hA5);
    pads(1'b1, 8'hA5, 8'h5A);
    tick(1);
    chk("mid_inv_O3", O, 32'hA5);
    tick(1);
    chk("mid_inv_O4", O, 32'hA5);
    chk("mid_inv_ERR_hold", ERR_CNT, 32'h02);

    // Channel 3 stuck at (1,1): error counter saturates
    pads(1'b1, 8'hAD, 8'h5A);
    tick(252);
    chk("sat_254", ERR_CNT, 32'hFE);
    tick(1);
    chk("sat_255", ERR_CNT, 32'hFF);
    tick(47);
    chk("sat_hold", ERR_CNT, 32'hFF);
    chk("sat_O_held", O, 32'hA5);
    chk("sat_RX_VALID", RX_VALID, 32'h0);
    ERR_CLR = 1'b1;
    tick(1);
    chk("clr_ERR", ERR_CNT, 32'h00);
    ERR_CLR = 1'b0;
    tick(1);
    chk("clr_then_count", ERR_CNT, 32'h01);

    // Asynchronous reset in the middle of TX
    pads(1'b1, 8'hA5, 8'h5A);
    DRIVE_REQ = 1'b1;
    I         = 8'h5A;
    tick(2);
    pads(1'b0, 8'h00, 8'h00);
    tick(1);
    chk("tx3_DRIVING", DRIVING, 32'h1);
    chk("tx3_IO", IO, 32'h5A);
    #2 RST_N = 1'b0;
    #1;
    chk("arst_DRIVING", DRIVING, 32'h0);
    chk("arst_BUSY", BUSY, 32'h0);
    chk("arst_O", O, 32'h00);
    chk("arst_RX_VALID", RX_VALID, 32'h0);
    chk("arst_ERR", ERR_CNT, 32'h00);
    pads(1'b1, 8'h00, 8'h00);
    #1;
    chk("arst_IO_z", IO, 32'h00);
    chk("arst_IOB_z", IOB, 32'h00);
    DRIVE_REQ = 1'b0;
    #1 RST_N = 1'b1;
    tick(1);
    chk("post_rst_BUSY", BUSY, 32'h0);
    chk("post_rst_DRIVING", DRIVING, 32'h0);
    DRIVE_REQ = 1'b1;
    tick(1);
    chk("post_rst_turn", BUSY, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
